// File: rtl/gate_unit_pkg.sv
// Shared types and the bitwise gate function for the gate_unit_pipe slice.
package gate_unit_pkg;

  // Widest operand gate_f handles; callers zero-extend in and truncate out.
  localparam int unsigned GATE_MAX_W = 256;

  typedef enum logic [2:0] {
    OP_NAND = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic {MODE_STREAM = 1'b0, MODE_FOLD = 1'b1} mode_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_FOLD = 1'b1} state_e;

  typedef logic [GATE_MAX_W-1:0] gate_word_t;

  function automatic gate_word_t gate_f(input op_e op, input gate_word_t x, input gate_word_t y);
    gate_word_t r;
    r = x;
    case (op)
      OP_NAND: r = ~(x & y);
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_NOT:  r = ~x;
      OP_PASS: r = x;
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_unit_pipe_sync_fifo.sv
// Small synchronous FIFO; reset clears pointers and occupancy, storage is left as is.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/gate_unit_pipe.sv
// WIDTH-bit bitwise gate unit with STREAM and FOLD modes, valid/ready in and out,
// and a small result FIFO carrying {result, beat count}.
module gate_unit_pipe
  import gate_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       opSel,
  input  logic             mode,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outY,
  output logic [CNT_W-1:0] outCount,
  output logic             foldBusy
);

  localparam int unsigned DW = WIDTH + CNT_W;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;

  logic             accept;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] push_y;
  logic [CNT_W-1:0] push_cnt;
  logic [WIDTH-1:0] gate_in;
  logic [WIDTH-1:0] gate_fold;
  logic [CNT_W-1:0] cnt_inc;

  logic [DW-1:0]    head_data;
  logic             fifo_full;
  logic             fifo_empty;

  // Handshakes depend only on FIFO occupancy, never on outReady combinationally.
  assign inReady  = !fifo_full;
  assign outValid = !fifo_empty;
  assign accept   = inValid & inReady;
  assign pop      = outValid & outReady;
  assign foldBusy = (state_q == ST_FOLD);

  // Empty FIFO presents zeros rather than whatever the storage last held.
  assign outY     = outValid ? head_data[DW-1:CNT_W] : '0;
  assign outCount = outValid ? head_data[CNT_W-1:0]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NAND;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    gate_in   = WIDTH'(gate_f(op_e'(opSel), GATE_MAX_W'(inA), GATE_MAX_W'(inB)));
    gate_fold = WIDTH'(gate_f(op_q, GATE_MAX_W'(acc_q), GATE_MAX_W'(inA)));
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and push decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    push     = 1'b0;
    push_y   = '0;
    push_cnt = '0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (mode == 1'(MODE_FOLD) && !inLast) begin
            acc_d   = gate_in;
            op_d    = op_e'(opSel);
            cnt_d   = CNT_W'(1);
            state_d = ST_FOLD;
          end else begin
            push     = 1'b1;
            push_y   = gate_in;
            push_cnt = CNT_W'(1);
          end
        end
        ST_FOLD: begin
          if (inLast) begin
            push     = 1'b1;
            push_y   = gate_fold;
            push_cnt = cnt_inc;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            acc_d = gate_fold;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_y, push_cnt}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Directed self-checking bench for gate_unit_pipe (default build plus a CNT_W=2 build).
module tb_gate_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid;
  logic [7:0] inA, inB;
  logic [2:0] opSel;
  logic       mode, inLast, outReady;

  logic       inReady, outValid, foldBusy;
  logic [7:0] outY, outCount;

  logic       sat_in_ready, sat_out_valid, sat_fold_busy;
  logic [7:0] sat_out_y;
  logic [1:0] sat_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_unit_pipe #(.WIDTH(8), .FIFO_DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB), .opSel(opSel), .mode(mode), .inLast(inLast),
    .outValid(outValid), .outReady(outReady), .outY(outY),
    .outCount(outCount), .foldBusy(foldBusy)
  );

  gate_unit_pipe #(.WIDTH(8), .FIFO_DEPTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(sat_in_ready),
    .inA(inA), .inB(inB), .opSel(opSel), .mode(mode), .inLast(inLast),
    .outValid(sat_out_valid), .outReady(outReady), .outY(sat_out_y),
    .outCount(sat_out_count), .foldBusy(sat_fold_busy)
  );

  // Present one beat, clock it, and settle just after the edge.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic md, input logic last);
    inValid = 1'b1; inA = a; inB = b; opSel = op; mode = md; inLast = last;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0; inLast = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inValid = 1'b0; inA = '0; inB = '0; opSel = '0;
    mode = 1'b0; inLast = 1'b0; outReady = 1'b1;
    #2;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || foldBusy !== 1'b0 ||
        outY !== 8'h00 || outCount !== 8'h00) begin
      errors++;
      $display("FAIL reset_values got v=%b r=%b fb=%b y=%h c=%h want 0 1 0 00 00",
               outValid, inReady, foldBusy, outY, outCount);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_stream;
    logic [7:0] exp_y [8];
    exp_y = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0);
      checks++;
      if (outValid !== 1'b1 || outY !== exp_y[i] || outCount !== 8'd1) begin
        errors++;
        $display("FAIL stream_op%0d got v=%b y=%h c=%0d want v=1 y=%h c=1",
                 i, outValid, outY, outCount, exp_y[i]);
      end
    end
    idle(1);
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got v=%b want 0", outValid);
    end
  endtask

  task automatic test_fold_nand;
    outReady = 1'b1;
    beat(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
    checks++;
    if (foldBusy !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL fold_beat1 got fb=%b v=%b want fb=1 v=0", foldBusy, outValid);
    end
    beat(8'h0F, 8'h00, 3'd5, 1'b0, 1'b0);
    checks++;
    if (foldBusy !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL fold_beat2 got fb=%b v=%b want fb=1 v=0", foldBusy, outValid);
    end
    beat(8'hAA, 8'h00, 3'd1, 1'b0, 1'b1);
    checks++;
    if (foldBusy !== 1'b0 || outValid !== 1'b1 || outY !== 8'h55 || outCount !== 8'd3) begin
      errors++;
      $display("FAIL fold_nand_result got fb=%b v=%b y=%h c=%0d want fb=0 v=1 y=55 c=3",
               foldBusy, outValid, outY, outCount);
    end
    idle(1);
  endtask

  task automatic test_fold_single;
    outReady = 1'b1;
    beat(8'h12, 8'h34, 3'd4, 1'b1, 1'b1);
    checks++;
    if (foldBusy !== 1'b0 || outValid !== 1'b1 || outY !== 8'h26 || outCount !== 8'd1) begin
      errors++;
      $display("FAIL fold_single got fb=%b v=%b y=%h c=%0d want fb=0 v=1 y=26 c=1",
               foldBusy, outValid, outY, outCount);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    outReady = 1'b0;
    beat(8'h01, 8'h00, 3'd4, 1'b0, 1'b0);
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b1 || outY !== 8'h01) begin
      errors++;
      $display("FAIL bp_first got r=%b v=%b y=%h want r=1 v=1 y=01", inReady, outValid, outY);
    end
    beat(8'h02, 8'h00, 3'd4, 1'b0, 1'b0);
    checks++;
    if (inReady !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got r=%b want 0", inReady);
    end
    beat(8'h03, 8'h00, 3'd4, 1'b0, 1'b0);
    checks++;
    if (inReady !== 1'b0 || outY !== 8'h01 || outCount !== 8'd1) begin
      errors++;
      $display("FAIL bp_hold got r=%b y=%h c=%0d want r=0 y=01 c=1", inReady, outY, outCount);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b1 || outY !== 8'h02) begin
      errors++;
      $display("FAIL bp_drain1 got r=%b v=%b y=%h want r=1 v=1 y=02", inReady, outValid, outY);
    end
    @(posedge clk); #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b1 || outY !== 8'h03) begin
      errors++;
      $display("FAIL bp_push_pop got r=%b v=%b y=%h want r=1 v=1 y=03", inReady, outValid, outY);
    end
    idle(1);
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got v=%b want 0", outValid);
    end
  endtask

  task automatic test_saturation;
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) beat(8'h5A, 8'h00, 3'd7, 1'b1, (i == 5));
    checks++;
    if (sat_out_valid !== 1'b1 || sat_out_y !== 8'h5A || sat_out_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_count got v=%b y=%h c=%0d want v=1 y=5a c=3",
               sat_out_valid, sat_out_y, sat_out_count);
    end
    checks++;
    if (outValid !== 1'b1 || outY !== 8'h5A || outCount !== 8'd6) begin
      errors++;
      $display("FAIL fold_count6 got v=%b y=%h c=%0d want v=1 y=5a c=6",
               outValid, outY, outCount);
    end
    idle(1);
  endtask

  task automatic test_mid_reset;
    outReady = 1'b0;
    beat(8'h0A, 8'h00, 3'd7, 1'b0, 1'b0);
    beat(8'h0B, 8'h00, 3'd7, 1'b0, 1'b0);
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || inReady !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pre got v=%b r=%b want v=1 r=0", outValid, inReady);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || foldBusy !== 1'b0 || outY !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async got v=%b r=%b fb=%b y=%h want 0 1 0 00",
               outValid, inReady, foldBusy, outY);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    outReady = 1'b1;
    idle(2);
    checks++;
    if (outValid !== 1'b0 || foldBusy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_stale got v=%b fb=%b want 0 0", outValid, foldBusy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fold_nand();
    test_fold_single();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_unit_pipe.md
Name: gate_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit NAND gate: a WIDTH-bit bitwise logic unit with eight selectable gate ops.
- Two modes:
  - STREAM: one result per accepted beat.
  - FOLD: the op is applied sequentially across a multi-beat packet; one result is emitted on the last beat.
- Valid/ready on input and output, with a small output FIFO. Serves as the reusable gate primitive for bitworks datapath exercises.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- FIFO_DEPTH, 2, output FIFO entries (power of two, >=2)
- CNT_W, 8, width of beat counter / outCount

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  input beat valid
- inReady  out  1  unit can accept a beat
- inA  in  WIDTH  operand A
- inB  in  WIDTH  operand B
- opSel  in  3  0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A
- mode  in  1  0 STREAM, 1 FOLD
- inLast  in  1  last beat of FOLD packet (ignored in STREAM)
- outValid  out  1  FIFO head valid
- outReady  in  1  downstream accepts head
- outY  out  WIDTH  result at FIFO head
- outCount  out  CNT_W  beats in packet that produced outY (1 in STREAM)
- foldBusy  out  1  FOLD packet in progress

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; acc=0; cnt=0; FIFO empty. Reset values: outValid=0, outY=0, outCount=0, foldBusy=0, inReady=1.
- Mid-operation reset discards the partial fold and all FIFO contents.
- Accept = inValid & inReady.
- inReady = !fifo_full. It is registered/state-derived only, never combinational from outReady.
- Pop = outValid & outReady.
- Push and pop in the same cycle are allowed at any occupancy, including full: occupancy is unchanged. Note that inReady is low when full, so a push cannot occur while full.
- Gate function f(op,x,y), bitwise over WIDTH:
  - NAND ~(x&y); AND x&y; OR x|y; NOR ~(x|y); XOR x^y; XNOR ~(x^y); NOT ~x; PASS x.
- FSM states IDLE, FOLD.
- IDLE, accepted beat with mode=0 (STREAM):
  - push {f(opSel,inA,inB), 1}.
  - Latency: outValid rises the cycle after accept if FIFO was empty.
- IDLE, accepted beat with mode=1 (FOLD):
  - If inLast=1: push {f(opSel,inA,inB), 1}; stay IDLE.
  - Else: acc=f(opSel,inA,inB), latch op, cnt=1, go FOLD.
- FOLD, accepted beat:
  - r = f(latched op, acc, inA); inB, opSel and mode are ignored.
  - cnt_next = cnt+1, saturating at 2^CNT_W-1.
  - If inLast=0: acc=r, cnt=cnt_next.
  - If inLast=1: push {r, cnt_next}; clear acc and cnt; go IDLE.
- foldBusy = (state==FOLD).
- Every accepted beat is gated by inReady, including non-last FOLD beats, so packet progress stalls while the FIFO is full.
- outY/outCount are stable while outValid=1 and outReady=0.
- inValid=0 holds all state.

Decomposition:
- Package gate_unit_pkg:
  - typedef enum logic [2:0] op_e (OP_NAND..OP_PASS)
  - typedef enum logic {MODE_STREAM, MODE_FOLD} mode_e
  - typedef enum logic {ST_IDLE, ST_FOLD} state_e
  - function gate_f(op_e, x, y) parametrised via WIDTH-sized logic
- Sub-module sync_fifo (WIDTH+CNT_W data, FIFO_DEPTH). Provides full/empty and head data; reset clears pointers only.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 FIFO entries -> outValid=0, inReady=1, foldBusy=0 immediately (async); no stale output after release.
- STREAM truth table, WIDTH=8: inA=0xF0, inB=0xCC, sweep opSel 0..7 with outReady=1 -> outY = 0x3F, 0xC0, 0xFC, 0x03, 0x3C, 0xC3, 0x0F, 0xF0 in order, outCount=1 each, one-cycle latency.
- FOLD NAND: beats inA = 0xFF, 0x0F, 0xAA (last), beat1 inB=0xFF, opSel=0 -> acc 0x00, then 0xFF, then 0x55; single outY=0x55, outCount=3; foldBusy high from cycle after beat1 until after beat3.
- Single-beat FOLD: mode=1, inLast=1, opSel=4, inA=0x12, inB=0x34 -> outY=0x26, outCount=1, foldBusy never asserts.
- Backpressure: outReady=0, push 3 STREAM beats -> 2 stored, inReady=0 after 2nd, 3rd held. Release outReady -> results drain in order, no loss or duplication. Simultaneous push/pop at occupancy 1 keeps occupancy 1.
- Counter saturation (CNT_W=2): 6-beat FOLD PASS packet -> outCount=3, outY=last inA.
